// File: rtl/mul_issue_sched_pkg.sv
// Shared definitions for the multiplier issue scheduler: op encodings, FSM states
// and the end-to-end latency the multiplier pipeline exhibits.
package mul_issue_sched_pkg;

  typedef enum logic [4:0] {
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPT
  } sched_state_e;

  // Request accept to mul_done, in cycles.
  localparam int MUL_LATENCY = 36;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

endpackage

// File: rtl/mul_issue_sched_if.sv
// Issue, multiplier and writeback signals of the scheduler; slave is the scheduler side.
interface mul_issue_sched_if #(
  parameter int QDEPTH = 4,
  parameter int TAG_W  = 6
);
  logic                      flush;
  logic                      req_valid;
  logic                      req_ready;
  logic [4:0]                req_op;
  logic [31:0]               req_a;
  logic [31:0]               req_b;
  logic [TAG_W-1:0]          req_tag;
  logic                      mul_start;
  logic [4:0]                mul_op_sel;
  logic [31:0]               mul_rs1;
  logic [31:0]               mul_rs2;
  logic                      mul_busy;
  logic                      mul_done;
  logic [31:0]               mul_result;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [TAG_W-1:0]          wb_tag;
  logic [31:0]               wb_data;
  logic [$clog2(QDEPTH):0]   q_count;

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_tag,
           mul_busy, mul_done, mul_result, wb_ready,
    output req_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2,
           wb_valid, wb_tag, wb_data, q_count
  );

  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_tag,
           mul_busy, mul_done, mul_result, wb_ready,
    input  req_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2,
           wb_valid, wb_tag, wb_data, q_count
  );
endinterface

// File: rtl/mul_issue_sched_fifo.sv
// In-order request FIFO; flush empties it in one cycle, write+read on full is allowed.
module mul_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic                    i_wr,
  input  logic [W-1:0]            i_wdata,
  input  logic                    i_rd,
  output logic [W-1:0]            o_rdata,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr, w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_rd    = i_rd & ~o_empty;
  assign w_wr    = i_wr & (~o_full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mul_issue_sched.sv
// Issue scheduler for the shared iterative multiplier: in-order request queue,
// one op in flight, result capture and a one-entry writeback buffer.
module mul_issue_sched
  import mul_issue_sched_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int TAG_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_issue_sched_if.slave io
);
  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  sched_state_e     r_state, w_state_nxt;
  req_t             w_wr_req, w_head;
  logic             w_empty, w_full, w_push, w_pop;
  logic             r_live, r_kill, w_kill_set, w_kill_clr;
  logic             w_wb_drain, w_wb_load;
  logic [4:0]       r_op;
  logic [31:0]      r_a, r_b, r_wb_data;
  logic [TAG_W-1:0] r_tag, r_wb_tag;
  logic             r_wb_valid;

  // r_live holds req_ready low for the first cycle after reset release.
  assign io.req_ready = r_live & ~w_full & ~io.flush;
  assign w_push       = io.req_valid & io.req_ready;
  assign w_wr_req     = '{op: io.req_op, a: io.req_a, b: io.req_b, tag: io.req_tag};

  mul_req_fifo #(.DEPTH(QDEPTH), .W($bits(req_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (io.flush),
    .i_wr    (w_push),
    .i_wdata (w_wr_req),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (io.q_count)
  );

  assign io.mul_start  = (r_state == S_START);
  assign io.mul_op_sel = r_op;
  assign io.mul_rs1    = r_a;
  assign io.mul_rs2    = r_b;
  assign io.wb_valid   = r_wb_valid;
  assign io.wb_tag     = r_wb_tag;
  assign io.wb_data    = r_wb_data;
  assign w_wb_drain    = r_wb_valid & io.wb_ready;
  assign w_kill_set    = io.flush & ((r_state == S_START) | (r_state == S_WAIT));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_wb_load   = 1'b0;
    w_kill_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !io.flush && !io.mul_busy && !io.mul_done) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (io.mul_done) w_state_nxt = S_CAPT;
      S_CAPT: begin
        // A flush landing in this very cycle discards the result immediately.
        if (r_kill || io.flush) begin
          w_kill_clr  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!r_wb_valid || w_wb_drain) begin
          w_wb_load   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_kill_clr)      r_kill <= 1'b0;
      else if (w_kill_set) r_kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
    end else if (w_pop) begin
      r_op  <= w_head.op;
      r_a   <= w_head.a;
      r_b   <= w_head.b;
      r_tag <= w_head.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
    end else begin
      if (w_wb_load) begin
        r_wb_valid <= 1'b1;
        r_wb_tag   <= r_tag;
        r_wb_data  <= io.mul_result;
      end else if (w_wb_drain || io.flush) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

endmodule
